floor_request_latch: RTL



---
 rtl/floor_request_latch_pkg.sv | 19 +
 rtl/floor_request_latch_if.sv | 24 ++
 rtl/floor_request_latch_debounce.sv | 42 ++++
 rtl/floor_request_latch.sv | 88 ++++++++
 4 files changed

// File: rtl/floor_request_latch_pkg.sv
// Shared elevator constants: floor count, floor encoding limits and travel direction codes.
package elevator_pkg;

  localparam int NUM_FLOORS = 6;

  localparam logic [2:0] FLOOR_MIN = 3'd1;
  localparam logic [2:0] FLOOR_MAX = 3'd6;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Out-of-range car positions are pinned to the nearest real floor.
  function automatic logic [2:0] clamp_floor(input logic [2:0] f);
    if (f < FLOOR_MIN) return FLOOR_MIN;
    if (f > FLOOR_MAX) return FLOOR_MAX;
    return f;
  endfunction

endpackage

// File: rtl/floor_request_latch_if.sv
// Button bus and request handshake between the floor request latch and the elevator controller.
interface floor_request_latch_if;
  import elevator_pkg::*;

  logic [NUM_FLOORS-1:0] in;
  logic [2:0]            cur_floor;
  logic                  dir;
  logic                  serve_ack;
  logic [2:0]            serve_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  req_valid;
  logic [2:0]            req_floor;

  modport master (
    output in, cur_floor, dir, serve_ack, serve_floor,
    input  pending, req_valid, req_floor
  );

  modport slave (
    input  in, cur_floor, dir, serve_ack, serve_floor,
    output pending, req_valid, req_floor
  );

endinterface

// File: rtl/floor_request_latch_debounce.sv
// One floor button: two-flop synchroniser, debounce counter and stable state.
// press pulses combinationally on the edge where the stable state goes 0 -> 1.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic press
);

  logic             sync_q0;
  logic             sync_q1;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             at_limit;

  assign at_limit = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign press    = !stable && sync_q1 && at_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q0 <= 1'b0;
      sync_q1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q0 <= din;
      sync_q1 <= sync_q0;
      if (sync_q1 == stable) begin
        cnt <= '0;
      end else if (at_limit) begin
        stable <= sync_q1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/floor_request_latch.sv
// Latches debounced floor presses, clears them on controller ack, and registers the
// next target floor chosen by a direction-aware scan of the pending set.
module floor_request_latch
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  floor_request_latch_if.slave  bus
);

  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] clr;
  logic [NUM_FLOORS-1:0] pending_r;
  logic [NUM_FLOORS-1:0] pending_nxt;
  logic                  ack_ok;
  logic                  req_valid_r;
  logic [2:0]            req_floor_r;
  logic [2:0]            cf;
  logic [2:0]            ge_lowest;
  logic [2:0]            gt_lowest;
  logic [2:0]            le_highest;
  logic [2:0]            lt_highest;
  logic [2:0]            sel_floor;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .din  (bus.in[g]),
      .press(press[g])
    );
  end

  assign ack_ok = bus.serve_ack && (bus.serve_floor >= FLOOR_MIN) && (bus.serve_floor <= FLOOR_MAX);

  // Press is OR-ed in after the clear so a same-edge press beats an ack.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (ack_ok && (bus.serve_floor == 3'(i + 1))) clr[i] = 1'b1;
    end
    pending_nxt = (pending_r & ~clr) | press;
  end

  always_comb begin
    cf         = clamp_floor(bus.cur_floor);
    ge_lowest  = '0;
    gt_lowest  = '0;
    le_highest = '0;
    lt_highest = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_r[i] && (3'(i + 1) >= cf)) ge_lowest = 3'(i + 1);
      if (pending_r[i] && (3'(i + 1) >  cf)) gt_lowest = 3'(i + 1);
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_r[i] && (3'(i + 1) <= cf)) le_highest = 3'(i + 1);
      if (pending_r[i] && (3'(i + 1) <  cf)) lt_highest = 3'(i + 1);
    end
    if (bus.dir == DIR_DOWN) begin
      sel_floor = (le_highest != 3'd0) ? le_highest : gt_lowest;
    end else begin
      sel_floor = (ge_lowest != 3'd0) ? ge_lowest : lt_highest;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r   <= '0;
      req_valid_r <= 1'b0;
      req_floor_r <= '0;
    end else begin
      pending_r   <= pending_nxt;
      req_valid_r <= |pending_r;
      req_floor_r <= sel_floor;
    end
  end

  assign bus.pending   = pending_r;
  assign bus.req_valid = req_valid_r;
  assign bus.req_floor = req_floor_r;

endmodule
